// File: rtl/mxu_feeder.sv
// Host front end for the systolic matrix unit: operand store, skewed feed
// sequencer, status/irq and result readback over valid/ready handshakes.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   waddr_i/wdata_i/wvalid_i  host write request; wready_o = !busy
//   raddr_i/arvalid_i         host read address; arready_o = !rvalid_o
//   rdata_o/rvalid_o/rready_i registered read data, held until rready_i
//   a_out_o/b_out_o           skewed row/column operands to the array
//   acc_clr_o, mult_en_o      array accumulator clear / multiply enable
//   res_sel_o, res_data_i     result index out, combinational result in
//   irq_o                     one-cycle completion pulse
//
// Word map: 0 ctrl/status, 1 drain, then A, B (row-major), then results.
module mxu_feeder #(
    parameter int SIZE = 4,
    parameter int DW   = 8,
    parameter int RW   = 32,
    parameter int AW   = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [AW-1:0]                 waddr_i,
    input  logic [RW-1:0]                 wdata_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    input  logic [AW-1:0]                 raddr_i,
    input  logic                          arvalid_i,
    output logic                          arready_o,
    output logic [RW-1:0]                 rdata_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [SIZE*DW-1:0]            a_out_o,
    output logic [SIZE*DW-1:0]            b_out_o,
    output logic                          acc_clr_o,
    output logic                          mult_en_o,
    output logic [$clog2(SIZE*SIZE)-1:0]  res_sel_o,
    input  logic [RW-1:0]                 res_data_i,
    output logic                          irq_o
);

    localparam int N         = SIZE * SIZE;
    localparam int SW        = $clog2(N);
    localparam int A_BASE    = 2;
    localparam int B_BASE    = 2 + N;
    localparam int R_BASE    = 2 + 2 * N;
    localparam int R_END     = 2 + 3 * N;
    localparam int FEED_LAST = 2 * SIZE - 2;
    localparam int CLOG_FEED = $clog2(2 * SIZE);
    localparam int CW        = (CLOG_FEED > 8) ? CLOG_FEED : 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [DW-1:0]       a_q [N];
    logic [DW-1:0]       b_q [N];
    logic [7:0]          drain_q;
    logic [7:0]          dlen_q;
    logic                done_q;
    logic                err_q;

    logic [SIZE*DW-1:0]  a_out_q, a_out_d;
    logic [SIZE*DW-1:0]  b_out_q, b_out_d;
    logic                acc_clr_q, acc_clr_d;
    logic                mult_en_q, mult_en_d;
    logic                irq_q, irq_d;

    logic                rvalid_q;
    logic [RW-1:0]       rdata_q, rdata_d;

    logic                busy;
    logic                wr_acc;
    logic                rd_acc;
    logic                wr_ctrl;
    logic                start;
    logic                clr;
    logic                w_oob;
    logic                rd_err;
    logic                r_ctrl, r_drain, r_a, r_b, r_r;
    logic                unused_wdata;

    assign busy      = (state_q != S_IDLE);
    assign wready_o  = !busy;
    assign arready_o = !rvalid_q;
    assign wr_acc    = wvalid_i && wready_o;
    assign rd_acc    = arvalid_i && arready_o;

    assign wr_ctrl = wr_acc && (waddr_i == AW'(0));
    assign start   = wr_ctrl && wdata_i[0];
    assign clr     = wr_ctrl && wdata_i[1];
    assign w_oob   = wr_acc && (waddr_i >= AW'(R_BASE));

    // Only the low bits of wdata carry meaning for any writable word.
    assign unused_wdata = ^wdata_i;

    assign a_out_o   = a_out_q;
    assign b_out_o   = b_out_q;
    assign acc_clr_o = acc_clr_q;
    assign mult_en_o = mult_en_q;
    assign irq_o     = irq_q;
    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;

    // ---------------- sequencer: state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- sequencer: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CW'(FEED_LAST)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(dlen_q) - CW'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- sequencer: outputs ----------------
    // Row i carries A[i][t-i] and column j carries B[t-j][j]; enumerating
    // (lane, k) pairs keeps every storage index a constant.
    always_comb begin
        a_out_d   = '0;
        b_out_d   = '0;
        acc_clr_d = 1'b0;
        mult_en_d = 1'b0;
        irq_d     = 1'b0;
        unique case (state_q)
            S_CLR: begin
                acc_clr_d = 1'b1;
            end
            S_FEED: begin
                mult_en_d = 1'b1;
                for (int i = 0; i < SIZE; i++) begin
                    for (int k = 0; k < SIZE; k++) begin
                        if (cnt_q == CW'(i + k)) begin
                            a_out_d[i*DW +: DW] = a_q[i*SIZE + k];
                            b_out_d[i*DW +: DW] = b_q[k*SIZE + i];
                        end
                    end
                end
            end
            S_DRAIN: begin
                mult_en_d = 1'b1;
            end
            S_DONE: begin
                irq_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_out_q   <= '0;
            b_out_q   <= '0;
            acc_clr_q <= 1'b0;
            mult_en_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
            acc_clr_q <= acc_clr_d;
            mult_en_q <= mult_en_d;
            irq_q     <= irq_d;
        end
    end

    // ---------------- read decode ----------------
    always_comb begin
        r_ctrl  = (raddr_i == AW'(0));
        r_drain = (raddr_i == AW'(1));
        r_a     = (raddr_i >= AW'(A_BASE)) && (raddr_i < AW'(B_BASE));
        r_b     = (raddr_i >= AW'(B_BASE)) && (raddr_i < AW'(R_BASE));
        r_r     = (raddr_i >= AW'(R_BASE)) && (raddr_i < AW'(R_END));
    end

    always_comb begin
        rdata_d   = '0;
        rd_err    = 1'b0;
        res_sel_o = '0;
        if (arvalid_i && r_r) begin
            res_sel_o = SW'(raddr_i - AW'(R_BASE));
        end
        unique case (1'b1)
            r_ctrl: begin
                rdata_d = {{(RW-3){1'b0}}, err_q, done_q, busy};
            end
            r_drain: begin
                rdata_d = RW'(drain_q);
            end
            r_a: begin
                rdata_d = RW'(a_q[SW'(raddr_i - AW'(A_BASE))]);
            end
            r_b: begin
                rdata_d = RW'(b_q[SW'(raddr_i - AW'(B_BASE))]);
            end
            r_r: begin
                rdata_d = res_data_i;
            end
            default: begin
                rd_err = rd_acc;
            end
        endcase
    end

    // ---------------- storage, status, read channel ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < N; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            drain_q  <= 8'(SIZE);
            dlen_q   <= 8'd1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (wr_acc && waddr_i == AW'(A_BASE + k)) begin
                    a_q[k] <= wdata_i[DW-1:0];
                end
                if (wr_acc && waddr_i == AW'(B_BASE + k)) begin
                    b_q[k] <= wdata_i[DW-1:0];
                end
            end
            if (wr_acc && waddr_i == AW'(1)) begin
                drain_q <= wdata_i[7:0];
            end
            // A zero drain length still gives the array one flush cycle.
            if (start) begin
                dlen_q <= (drain_q == 8'd0) ? 8'd1 : drain_q;
            end
            if (clr || start) begin
                done_q <= 1'b0;
            end else if (state_q == S_DONE) begin
                done_q <= 1'b1;
            end
            // Clear is applied first so a same-cycle error still sticks.
            if (w_oob || rd_err) begin
                err_q <= 1'b1;
            end else if (clr) begin
                err_q <= 1'b0;
            end
            if (rd_acc) begin
                rdata_q  <= rdata_d;
                rvalid_q <= 1'b1;
            end else if (rvalid_q && rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule
